// File: rtl/security_zone_ctrl.sv
// Multi-zone intrusion controller: exit/entry delays, bounded alarm with lockout,
// and a tamper input that forces the alarm regardless of arming.
module security_zone_ctrl #(
  parameter int                   NUM_ZONES   = 4,
  parameter logic [NUM_ZONES-1:0] DELAY_ZONES = NUM_ZONES'(4'b0001),
  parameter int                   EXIT_DELAY  = 16,
  parameter int                   ENTRY_DELAY = 16,
  parameter int                   ALARM_TIME  = 64,
  parameter int                   CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [NUM_ZONES-1:0] zone_in,
  input  logic [NUM_ZONES-1:0] zone_mask,
  input  logic                 tamper,
  output logic                 alarm,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     timer,
  output logic [NUM_ZONES-1:0] zone_latched,
  output logic                 tamper_latched,
  output logic                 arm_fault
);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_TIME - 1);

  state_t               state_q;
  logic [NUM_ZONES-1:0] act, dly, inst;

  assign act   = zone_in & zone_mask;
  assign dly   = act & DELAY_ZONES;
  assign inst  = act & ~DELAY_ZONES;
  assign state = state_q;

  // NOTE: every register here uses <= so all of them see pre-edge values; a
  // later <= to the same register in this block overrides an earlier one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_DISARMED;
      timer          <= '0;
      alarm          <= 1'b0;
      zone_latched   <= '0;
      tamper_latched <= 1'b0;
      arm_fault      <= 1'b0;
    end else begin
      arm_fault <= 1'b0;
      if (disarm) begin
        state_q        <= ST_DISARMED;
        timer          <= '0;
        alarm          <= 1'b0;
        zone_latched   <= '0;
        tamper_latched <= 1'b0;
      end else begin
        if (state_q inside {ST_ARMED, ST_ENTRY, ST_ALARM})
          zone_latched <= zone_latched | act;

        // Tamper outranks the state rules except inside ALARM, where it must not
        // extend the alarm.
        if (tamper && state_q != ST_ALARM) begin
          state_q        <= ST_ALARM;
          timer          <= ALARM_LOAD;
          alarm          <= 1'b1;
          tamper_latched <= 1'b1;
        end else begin
          unique case (state_q)
            ST_DISARMED: begin
              if (arm) begin
                if (act == '0) begin
                  state_q        <= ST_EXIT;
                  timer          <= EXIT_LOAD;
                  zone_latched   <= '0;
                  tamper_latched <= 1'b0;
                end else begin
                  arm_fault <= 1'b1;
                end
              end
            end
            ST_EXIT: begin
              if (timer == '0) state_q <= ST_ARMED;
              else             timer   <= timer - 1'b1;
            end
            ST_ARMED: begin
              if (inst != '0) begin
                state_q <= ST_ALARM;
                timer   <= ALARM_LOAD;
                alarm   <= 1'b1;
              end else if (dly != '0) begin
                state_q <= ST_ENTRY;
                timer   <= ENTRY_LOAD;
              end
            end
            ST_ENTRY: begin
              if (inst != '0 || timer == '0) begin
                state_q <= ST_ALARM;
                timer   <= ALARM_LOAD;
                alarm   <= 1'b1;
              end else begin
                timer <= timer - 1'b1;
              end
            end
            ST_ALARM: begin
              if (timer == '0) begin
                state_q <= ST_LOCKOUT;
                alarm   <= 1'b0;
              end else begin
                timer <= timer - 1'b1;
              end
            end
            ST_LOCKOUT: ;
            default: begin
              state_q <= ST_DISARMED;
              timer   <= '0;
              alarm   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_security_zone_ctrl.sv
// Self-checking bench for security_zone_ctrl: directed vector table, hand-written
// timing sequences, and random traffic compared against an elapsed-time model.
module tb_security_zone_ctrl;

  localparam int NZ    = 4;
  localparam int EXIT_D  = 16;
  localparam int ENTRY_D = 16;
  localparam int ALARM_D = 64;
  localparam int DZ    = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0, disarm = 1'b0, tamper = 1'b0;
  logic [3:0] zone_in = '0, zone_mask = 4'hF;
  logic       alarm, tamper_latched, arm_fault;
  logic [2:0] state;
  logic [7:0] timer;
  logic [3:0] zone_latched;

  security_zone_ctrl #(
    .NUM_ZONES(NZ), .DELAY_ZONES(4'b0001), .EXIT_DELAY(EXIT_D),
    .ENTRY_DELAY(ENTRY_D), .ALARM_TIME(ALARM_D), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .zone_in(zone_in),
    .zone_mask(zone_mask), .tamper(tamper), .alarm(alarm), .state(state),
    .timer(timer), .zone_latched(zone_latched), .tamper_latched(tamper_latched),
    .arm_fault(arm_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state number plus cycles spent in it; the timer is derived from the
  // remaining dwell rather than stored.
  int m_st, m_el, m_zl, m_tl, m_f;

  task automatic model_reset();
    m_st = 0; m_el = 0; m_zl = 0; m_tl = 0; m_f = 0;
  endtask

  task automatic go(input int s);
    m_st = s; m_el = 0;
  endtask

  function automatic int dwell(input int s);
    case (s)
      1: return EXIT_D;
      3: return ENTRY_D;
      4: return ALARM_D;
      default: return 0;
    endcase
  endfunction

  function automatic int m_timer();
    return (dwell(m_st) == 0) ? 0 : dwell(m_st) - 1 - m_el;
  endfunction

  task automatic model_step();
    int a, d, i;
    a = int'(zone_in & zone_mask);
    d = a & DZ;
    i = a & ~DZ & 15;
    m_f = 0;
    if (disarm) begin
      go(0); m_zl = 0; m_tl = 0;
    end else begin
      if (m_st == 2 || m_st == 3 || m_st == 4) m_zl = m_zl | a;
      if (tamper && m_st != 4) begin
        go(4); m_tl = 1;
      end else if (m_st == 0) begin
        if (arm && a == 0) begin go(1); m_zl = 0; m_tl = 0; end
        else if (arm) m_f = 1;
      end else if (m_st == 2) begin
        if (i != 0) go(4);
        else if (d != 0) go(3);
      end else if (m_st == 3 && i != 0) begin
        go(4);
      end else if (m_st == 1 || m_st == 3 || m_st == 4) begin
        if (m_el + 1 >= dwell(m_st)) go(m_st == 1 ? 2 : m_st == 3 ? 4 : 5);
        else m_el++;
      end
    end
  endtask

  function automatic int unsigned pack(input int al, input int st, input int tm,
                                       input int zl, input int tl, input int f);
    return ((al & 1) << 17) | ((st & 7) << 14) | ((tm & 255) << 6) |
           ((zl & 15) << 2) | ((tl & 1) << 1) | (f & 1);
  endfunction

  function automatic int unsigned dut_pack();
    return pack(int'(alarm), int'(state), int'(timer), int'(zone_latched),
                int'(tamper_latched), int'(arm_fault));
  endfunction

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic cycle(input string name);
    @(posedge clk);
    model_step();
    #1;
    check(name, dut_pack(), pack(m_st == 4 ? 1 : 0, m_st, m_timer(), m_zl, m_tl, m_f));
  endtask

  typedef struct {
    logic       arm, disarm, tamper;
    logic [3:0] zin, mask;
    logic [2:0] st;
    logic [7:0] tm;
    logic       al, f, tl;
    logic [3:0] zl;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic d, input logic t,
                              input logic [3:0] zi, input logic [3:0] mk_mask,
                              input logic [2:0] st, input logic [7:0] tm,
                              input logic al, input logic f, input logic tl);
    vec_t v;
    v.arm = a; v.disarm = d; v.tamper = t; v.zin = zi; v.mask = mk_mask;
    v.st = st; v.tm = tm; v.al = al; v.f = f; v.tl = tl; v.zl = 4'h0;
    return v;
  endfunction

  vec_t vecs[10];
  int   n;

  initial begin
    //            arm dis tmp zin   mask   st  tmr al f tl
    vecs[0] = mk(1, 0, 0, 4'h2, 4'hF, 0, 0,  0, 1, 0); // tripped enabled zone: arm rejected
    vecs[1] = mk(1, 0, 0, 4'h2, 4'hD, 1, 15, 0, 0, 0); // same zone masked: arm accepted
    vecs[2] = mk(0, 0, 0, 4'h0, 4'hF, 1, 14, 0, 0, 0);
    vecs[3] = mk(0, 1, 0, 4'h0, 4'hF, 0, 0,  0, 0, 0);
    vecs[4] = mk(0, 0, 1, 4'h0, 4'hF, 4, 63, 1, 0, 1); // tamper while disarmed
    vecs[5] = mk(0, 0, 1, 4'h0, 4'hF, 4, 62, 1, 0, 1); // tamper in ALARM ignored
    vecs[6] = mk(0, 1, 1, 4'h0, 4'hF, 0, 0,  0, 0, 0); // disarm beats tamper
    vecs[7] = mk(0, 0, 1, 4'h0, 4'hF, 4, 63, 1, 0, 1);
    vecs[8] = mk(1, 0, 0, 4'h0, 4'hF, 4, 62, 1, 0, 1); // arm outside DISARMED: no fault
    vecs[9] = mk(0, 1, 0, 4'h0, 4'hF, 0, 0,  0, 0, 0);

    model_reset();
    #2;
    check("reset_values", dut_pack(), pack(0, 0, 0, 0, 0, 0));
    #10 rst_n = 1'b1;

    foreach (vecs[k]) begin
      arm = vecs[k].arm; disarm = vecs[k].disarm; tamper = vecs[k].tamper;
      zone_in = vecs[k].zin; zone_mask = vecs[k].mask;
      cycle("vec_model");
      check($sformatf("vec%0d", k), dut_pack(),
            pack(int'(vecs[k].al), int'(vecs[k].st), int'(vecs[k].tm),
                 int'(vecs[k].zl), int'(vecs[k].tl), int'(vecs[k].f)));
    end
    arm = 0; disarm = 0; tamper = 0; zone_in = 0; zone_mask = 4'hF;

    // Exit delay dwell.
    arm = 1; cycle("exit_start"); arm = 0;
    check("exit_entered", int'(state), 1);
    n = 1;
    for (int c = 0; c < 40; c++) begin
      cycle("exit_run");
      if (state != 3'd1) break;
      n++;
    end
    check("exit_dwell", n, EXIT_D);
    check("armed_after_exit", int'(state), 2);

    // Entry delay, alarm duration, lockout.
    zone_in = 4'b0001; cycle("entry_start"); zone_in = 0;
    check("entry_entered", int'(state), 3);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      cycle("entry_run"); n++;
      if (alarm) break;
    end
    check("entry_to_alarm", n, ENTRY_D);
    n = 1;
    for (int c = 0; c < 200; c++) begin
      cycle("alarm_run");
      if (!alarm) break;
      n++;
    end
    check("alarm_dwell", n, ALARM_D);
    check("lockout_state", int'(state), 5);
    check("lockout_zl", int'(zone_latched), 4'b0001);
    repeat (3) cycle("lockout_hold");

    // Instant zone during ENTRY.
    disarm = 1; cycle("dis1"); disarm = 0;
    arm = 1; cycle("arm1"); arm = 0;
    repeat (EXIT_D) cycle("exit1");
    check("armed1", int'(state), 2);
    zone_in = 4'b0001; cycle("entry1"); zone_in = 0;
    repeat (3) cycle("entry1_run");
    zone_in = 4'b0100; cycle("inst_in_entry"); zone_in = 0;
    check("inst_alarm_state", int'(state), 4);
    check("inst_alarm_zl", int'(zone_latched), 4'b0101);

    // Masked zone while armed.
    disarm = 1; cycle("dis2"); disarm = 0;
    arm = 1; cycle("arm2"); arm = 0;
    repeat (EXIT_D) cycle("exit2");
    zone_mask = 4'b0111; zone_in = 4'b1000;
    repeat (5) cycle("masked_zone");
    check("masked_stays_armed", int'(state), 2);
    zone_in = 0; zone_mask = 4'hF;

    // Disarm plus tamper mid-alarm, then async reset mid-alarm.
    disarm = 1; cycle("dis3"); disarm = 0;
    tamper = 1; cycle("tamper_alarm"); tamper = 0;
    repeat (33) cycle("alarm_count");
    check("alarm_timer_30", int'(timer), 30);
    disarm = 1; tamper = 1; cycle("dis_tamper");
    check("dis_tamper_out", dut_pack(), pack(0, 0, 0, 0, 0, 0));
    disarm = 0; cycle("tamper_again");
    check("tamper_again_state", int'(state), 4);
    tamper = 0;
    repeat (5) cycle("alarm_more");
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_pack(), pack(0, 0, 0, 0, 0, 0));
    model_reset();
    #1 rst_n = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      arm       = ($urandom % 6) == 0;
      disarm    = ($urandom % 50) == 0;
      tamper    = ($urandom % 80) == 0;
      zone_mask = 4'($urandom);
      zone_in   = (($urandom % 5) == 0) ? 4'($urandom) : 4'h0;
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
